// File: rtl/kamus_pkg.sv
// Shared types for the kamus L1 data-memory path.
package kamus_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_size_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } l1d_state_e;

    // Index is sized for the largest possible array; unused high bits stay 0.
    typedef struct packed {
        logic        valid;
        logic [29:0] idx;
        logic [31:0] data;
        logic [3:0]  mask;
    } wbuf_t;

endpackage

// File: rtl/kamus_l1d_lane_fmt.sv
// Byte-lane formatting: store mask/replication and load extraction/extension.
module kamus_l1d_lane_fmt
    import kamus_pkg::*;
(
    input  mem_size_e   st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_mask_o,
    output logic [31:0] st_data_o,
    input  mem_size_e   ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_mask_o = '0;
        st_data_o = '0;
        case (st_size_i)
            BYTE: begin
                st_mask_o = 4'b0001 << st_off_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            HALF: begin
                st_mask_o = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
            end
            WORD: begin
                st_mask_o = 4'b1111;
                st_data_o = st_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = ld_word_i[{ld_off_i, 3'b000} +: 8];
        ld_half   = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = '0;
        case (ld_size_i)
            BYTE: ld_data_o = ld_unsigned_i ? {24'b0, ld_byte}
                                            : {{24{ld_byte[7]}}, ld_byte};
            HALF: ld_data_o = ld_unsigned_i ? {16'b0, ld_half}
                                            : {{16{ld_half[15]}}, ld_half};
            WORD: ld_data_o = ld_word_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/kamus_l1d_ram.sv
// L1 data-memory responder: single-port word array, one-entry write buffer,
// store-to-load forwarding, and a post-reset zero-fill FSM.
module kamus_l1d_ram
    import kamus_pkg::*;
#(
    parameter int unsigned DEPTH          = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam l1d_state_e EXIT_ST = CLEAR_ON_RESET ? INIT : RUN;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   rd_q;

    l1d_state_e    state_q, state_d;
    logic [IW-1:0] clr_q, clr_d;
    wbuf_t         wbuf_q, wbuf_d;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_ld_q, rsp_ld_d;
    mem_size_e     rsp_size_q, rsp_size_d;
    logic [1:0]    rsp_off_q, rsp_off_d;
    logic          rsp_uns_q, rsp_uns_d;
    logic [3:0]    fwd_mask_q, fwd_mask_d;
    logic [31:0]   fwd_data_q, fwd_data_d;

    mem_size_e     size;
    logic [IW-1:0] idx;
    logic          misaligned, err;
    logic          acc, ld_acc, st_acc, drain, fwd_hit;
    logic [3:0]    st_mask;
    logic [31:0]   st_data;
    logic          mem_we;
    logic [IW-1:0] mem_widx;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic [31:0]   merged, ld_data;
    logic          unused_idx;

    assign size       = mem_size_e'(req_size_i);
    assign idx        = req_addr_i[IW+1:2];
    assign unused_idx = ^wbuf_q.idx[29:IW];

    always_comb begin
        misaligned = 1'b0;
        case (size)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = req_addr_i[0];
            WORD:    misaligned = |req_addr_i[1:0];
            default: misaligned = 1'b1;
        endcase
        err = misaligned | (|(req_addr_i >> (IW + 2)));
    end

    assign req_ready_o = (state_q == RUN) && !rst_i;
    assign acc         = req_valid_i && req_ready_o;
    assign ld_acc      = acc && !req_we_i && !err;
    assign st_acc      = acc && req_we_i && !err;
    // Loads own the single port; the buffer only drains on cycles without one.
    assign drain       = req_ready_o && wbuf_q.valid && !ld_acc;
    assign fwd_hit     = wbuf_q.valid && (wbuf_q.idx == 30'(idx));

    kamus_l1d_lane_fmt u_fmt (
        .st_size_i     (size),
        .st_off_i      (req_addr_i[1:0]),
        .st_data_i     (req_wdata_i),
        .st_mask_o     (st_mask),
        .st_data_o     (st_data),
        .ld_size_i     (rsp_size_q),
        .ld_off_i      (rsp_off_q),
        .ld_unsigned_i (rsp_uns_q),
        .ld_word_i     (merged),
        .ld_data_o     (ld_data)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = clr_q;
        mem_wdata = '0;
        mem_wmask = 4'b1111;
        if (state_q == INIT && !rst_i) begin
            mem_we = 1'b1;
        end else if (drain) begin
            mem_we    = 1'b1;
            mem_widx  = wbuf_q.idx[IW-1:0];
            mem_wdata = wbuf_q.data;
            mem_wmask = wbuf_q.mask;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (ld_acc) rd_q <= mem_q[idx];
    end

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        wbuf_d  = wbuf_q;
        case (state_q)
            INIT: begin
                clr_d = clr_q + 1'b1;
                if (clr_q == IW'(DEPTH - 1)) state_d = RUN;
            end
            default: ;
        endcase
        if (drain) wbuf_d.valid = 1'b0;
        if (st_acc) begin
            wbuf_d.valid = 1'b1;
            wbuf_d.idx   = 30'(idx);
            wbuf_d.data  = st_data;
            wbuf_d.mask  = st_mask;
        end
        rsp_valid_d = acc;
        rsp_err_d   = acc && err;
        rsp_ld_d    = ld_acc;
        rsp_size_d  = size;
        rsp_off_d   = req_addr_i[1:0];
        rsp_uns_d   = req_unsigned_i;
        fwd_mask_d  = (ld_acc && fwd_hit) ? wbuf_q.mask : 4'b0000;
        fwd_data_d  = wbuf_q.data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EXIT_ST;
            clr_q       <= '0;
            wbuf_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_ld_q    <= 1'b0;
            rsp_size_q  <= BYTE;
            rsp_off_q   <= '0;
            rsp_uns_q   <= 1'b0;
            fwd_mask_q  <= '0;
            fwd_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_q       <= clr_d;
            wbuf_q      <= wbuf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_ld_q    <= rsp_ld_d;
            rsp_size_q  <= rsp_size_d;
            rsp_off_q   <= rsp_off_d;
            rsp_uns_q   <= rsp_uns_d;
            fwd_mask_q  <= fwd_mask_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : rd_q[8*b +: 8];
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_ld_q ? ld_data : 32'h0;

endmodule

// File: doc/kamus_l1d_ram.md
Name: kamus_l1d_ram

Overview:
L1 data-memory responder on the data-cache side of the kamus MEM-stage load/store interface. It accepts one load or store request per cycle and returns exactly one response per accepted request, one cycle later. It uses a single-port word array behind a one-entry write buffer, with store-to-load forwarding. A post-reset clear FSM zero-fills the array before the first request is accepted.

Parameters:
DEPTH, 1024, number of 32-bit words in the array; must be a power of two.
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset (INIT state); 0 = go straight to RUN.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted when valid & ready
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  32  byte address
req_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
rsp_valid_o  out  1  response valid; one-cycle pulse per accepted request
rsp_rdata_o  out  32  load data, extended; 0 for stores and errors
rsp_err_o  out  1  request was misaligned, out of range or illegal size

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values: req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0. The write buffer is invalidated.
- FSM has two states, INIT and RUN.
  - Exit from reset goes to INIT if CLEAR_ON_RESET=1, else RUN.
  - INIT: a clear counter writes 0 to word 0..DEPTH-1, one word per cycle, with req_ready_o=0. After the write to DEPTH-1 the FSM moves to RUN, so ready rises DEPTH cycles after reset deasserts.
  - RUN: req_ready_o=1 every cycle.
- Word index = req_addr_i[log2(DEPTH)+1:2].
- Error when any of these hold:
  - req_size_i=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:log2(DEPTH)+2] != 0.
- An erroring request has no array or buffer side effect. It returns rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0.
- Latency: a request accepted in cycle T responds in T+1. No back-to-back limitation; throughput is one request per cycle.
- Stores:
  - The byte mask is built from size and addr[1:0]; write data is replicated into the selected byte lanes.
  - The store is placed in the write buffer (valid, index, data, mask).
  - Its response carries rsp_rdata_o=0, rsp_err_o=0.
- Write-buffer drain:
  - The buffer drains into the array in any RUN cycle in which no load is accepted, and is then invalidated.
  - A store accepted in the same cycle refills the buffer after the drain. Stores therefore never stall.
- Loads:
  - The array is read in cycle T. If the buffer is valid with a matching index, its mask and data are captured at T into the response stage.
  - At T+1, buffered bytes override array bytes per mask. The addressed byte/half/word is then shifted down and sign- or zero-extended per req_unsigned_i. Word loads ignore req_unsigned_i.
- Back-to-back loads keep the buffer resident. Forwarding stays correct for any number of loads.
- Reset mid-operation (INIT or RUN): a pending buffered store is discarded, the in-flight response is dropped, and the FSM restarts per CLEAR_ON_RESET.
- Requests with req_valid_i=1 while req_ready_o=0 are ignored; the requester holds them.

Decomposition:
- kamus_pkg: mem_size_e (BYTE, HALF, WORD, ILLEGAL), l1d_state_e (INIT, RUN), typedef wbuf_t {valid, idx, data, mask}.
- One sub-module, kamus_l1d_lane_fmt. It is combinational and owns byte-mask generation, store-data replication, load extraction and extension. It is shared with future cache work.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=16, deassert reset -> req_ready_o=0 for 16 cycles, then 1; a load word at 0x3C returns 0x00000000.
- Store word 0xDEADBEEF @0x10, then idle, then load word @0x10 -> rsp_rdata_o=0xDEADBEEF; store response had rdata=0, err=0.
- Store byte 0x80 @0x21, next cycle load byte signed @0x21 (forwarded from buffer) -> 0xFFFFFF80; same sequence with unsigned -> 0x00000080.
- Store half 0xABCD @0x22 over word 0x11223344 @0x20, then load word @0x20 with no idle cycle -> 0xABCD3344.
- Load half @0x13, load word @0x42, req_size_i=11 @0x0, word @ out-of-range 0x100 (DEPTH=16) -> each gives rsp_err_o=1, rdata=0; the array is unchanged.
- Store @0x8 then assert rst_i before any idle cycle (CLEAR_ON_RESET=0) -> a later load @0x8 returns the pre-store value; rsp_valid_o=0 in the cycle after reset.
